// File: rtl/dlfloat16_to_int32_if.sv
// Operand/result bundle for the DLFloat16 to int32 converter.
// The producer drives in_valid/float_in; the converter returns the registered result and flags.
interface dlfloat16_to_int32_if;
   logic        in_valid;
   logic [15:0] float_in;
   logic        out_valid;
   logic [31:0] int_out;
   logic        invalid;
   logic        inexact;

   modport master (
      output in_valid,
      output float_in,
      input  out_valid,
      input  int_out,
      input  invalid,
      input  inexact
   );

   modport slave (
      input  in_valid,
      input  float_in,
      output out_valid,
      output int_out,
      output invalid,
      output inexact
   );
endinterface

// File: rtl/dlfloat16_to_int32.sv
// DLFloat16 (1/6/9, bias 31) to signed int32 converter with one registered stage.
// The default build truncates toward zero; define ROUND_NEAREST_EN for round-to-nearest-even.
module dlfloat16_to_int32 #(
   parameter int BIAS  = 31,
   parameter int OUT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dlfloat16_to_int32_if.slave  bus
);
   localparam logic [5:0] BIAS_C  = 6'(BIAS);
   localparam logic [5:0] EXP_MAX = 6'd63;

   logic             sign_s;
   logic [5:0]       exp_s;
   logic [9:0]       sig_s;
   logic [5:0]       rsh_s;
   logic [3:0]       rsh4_s;
   logic [5:0]       lsh_s;
   logic [9:0]       lost_mask_s;
   logic [9:0]       half_s;
   logic [32:0]      mag_s;
   logic [32:0]      mag_rnd_s;
   logic             guard_s;
   logic             sticky_s;
   logic             lost_s;
   logic             special_s;
   logic             incr_s;
   logic             ovf_s;
   logic [OUT_W-1:0] res_s;
   logic             inv_s;
   logic             inx_s;

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] int_out_q, int_out_d;
   logic             invalid_q, invalid_d;
   logic             inexact_q, inexact_d;

   assign sign_s = bus.float_in[15];
   assign exp_s  = bus.float_in[14:9];
   assign sig_s  = {1'b1, bus.float_in[8:0]};
   assign rsh4_s = rsh_s[3:0];

   // Magnitude alignment: right shift below 2^9, left shift above; guard/sticky feed rounding.
   always_comb begin
      rsh_s       = 6'd0;
      lsh_s       = 6'd0;
      lost_mask_s = 10'd0;
      half_s      = 10'd0;
      mag_s       = 33'd0;
      guard_s     = 1'b0;
      sticky_s    = 1'b0;
      lost_s      = 1'b0;
      special_s   = 1'b0;
      if (exp_s == 6'd0) begin
         mag_s = 33'd0;
      end else if (exp_s == EXP_MAX) begin
         special_s = 1'b1;
      end else if (exp_s < BIAS_C) begin
         // |x| < 1: only 0.5 <= |x| < 1 has the hidden bit as guard.
         lost_s = 1'b1;
         if (exp_s == BIAS_C - 6'd1) begin
            guard_s  = 1'b1;
            sticky_s = |bus.float_in[8:0];
         end else begin
            guard_s  = 1'b0;
            sticky_s = 1'b1;
         end
      end else if (exp_s <= BIAS_C + 6'd8) begin
         rsh_s       = BIAS_C + 6'd9 - exp_s;
         lost_mask_s = (10'd1 << rsh4_s) - 10'd1;
         half_s      = 10'd1 << (rsh4_s - 4'd1);
         mag_s       = {23'd0, sig_s >> rsh4_s};
         lost_s      = |(sig_s & lost_mask_s);
         guard_s     = |(sig_s & half_s);
         sticky_s    = |(sig_s & (lost_mask_s >> 1));
      end else begin
         lsh_s = exp_s - BIAS_C - 6'd9;
         mag_s = {23'd0, sig_s} << lsh_s;
      end
   end

`ifdef ROUND_NEAREST_EN
   assign incr_s = guard_s & (sticky_s | mag_s[0]);
`else
   assign incr_s = 1'b0;
`endif

   assign mag_rnd_s = mag_s + {32'd0, incr_s};

   // Only -2^31 is representable at magnitude 2^31; anything larger saturates.
   always_comb begin
      ovf_s = 1'b0;
      if (sign_s) begin
         ovf_s = (mag_rnd_s > 33'h0_8000_0000);
      end else begin
         ovf_s = (mag_rnd_s > 33'h0_7FFF_FFFF);
      end
   end

   // Apply sign or saturation and choose flags.
   always_comb begin
      res_s = 32'd0;
      inv_s = 1'b0;
      inx_s = 1'b0;
      if (special_s || ovf_s) begin
         res_s = sign_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
         inv_s = 1'b1;
         inx_s = 1'b0;
      end else begin
         res_s = sign_s ? (~mag_rnd_s[31:0] + 32'd1) : mag_rnd_s[31:0];
         inv_s = 1'b0;
         inx_s = lost_s;
      end
   end

   // Result and flags load only on a valid operand; otherwise they hold.
   always_comb begin
      out_valid_d = bus.in_valid;
      int_out_d   = int_out_q;
      invalid_d   = invalid_q;
      inexact_d   = inexact_q;
      if (bus.in_valid) begin
         int_out_d = res_s;
         invalid_d = inv_s;
         inexact_d = inx_s;
      end else begin
         int_out_d = int_out_q;
         invalid_d = invalid_q;
         inexact_d = inexact_q;
      end
   end

   // Output pipeline register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         int_out_q   <= 32'd0;
         invalid_q   <= 1'b0;
         inexact_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         int_out_q   <= int_out_d;
         invalid_q   <= invalid_d;
         inexact_q   <= inexact_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.int_out   = int_out_q;
   assign bus.invalid   = invalid_q;
   assign bus.inexact   = inexact_q;
endmodule

// File: tb/tb_dlfloat16_to_int32.sv
// Directed and randomized bench for dlfloat16_to_int32 against an arithmetic reference model.
module tb_dlfloat16_to_int32;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic        exp_ov;
   logic [31:0] exp_res;
   logic        exp_inv;
   logic        exp_inx;

   dlfloat16_to_int32_if bus_if ();

   dlfloat16_to_int32 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   // Value = (1 + F/512) * 2^(E-31); integer division gives truncation, remainder drives rounding.
   function automatic logic [33:0] model(input logic [15:0] f);
      logic   s;
      int     e;
      longint m, mag, rem, dv;
      logic   inx;
      logic [31:0] r;
      s = f[15];
      if (f[14:9] == 6'd0) return 34'd0;
      if (f[14:9] == 6'd63) return {1'b1, 1'b0, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
      e = int'(f[14:9]) - 31;
      m = 64'd512 + longint'(f[8:0]);
      if (e >= 9) begin
         mag = m << (e - 9);
         rem = 0;
         dv  = 1;
      end else begin
         dv  = longint'(1) << (9 - e);
         mag = m / dv;
         rem = m % dv;
      end
      inx = (rem != 0);
`ifdef ROUND_NEAREST_EN
      if ((2 * rem > dv) || ((2 * rem == dv) && (mag % 2 == 1))) mag = mag + 1;
`endif
      if ((!s && mag > 64'h7FFF_FFFF) || (s && mag > 64'h8000_0000))
         return {1'b1, 1'b0, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
      r = s ? 32'(-mag) : 32'(mag);
      return {1'b0, inx, r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".out_valid"}, 32'(bus_if.out_valid), 32'(exp_ov));
      chk({tag, ".int_out"},   bus_if.int_out,         exp_res);
      chk({tag, ".invalid"},   32'(bus_if.invalid),   32'(exp_inv));
      chk({tag, ".inexact"},   32'(bus_if.inexact),   32'(exp_inx));
   endtask

   // One clock: present operand, advance the expected registered state, check #1 after the edge.
   task automatic step(input logic v, input logic [15:0] f, input string tag);
      logic [33:0] m;
      bus_if.in_valid = v;
      bus_if.float_in = f;
      @(posedge clk);
      #1;
      exp_ov = v;
      if (v) begin
         m       = model(f);
         exp_inv = m[33];
         exp_inx = m[32];
         exp_res = m[31:0];
      end
      check_outputs(tag);
   endtask

   // Directed step with a hand-derived expectation in addition to the model.
   task automatic dstep(input logic [15:0] f, input logic [31:0] r, input logic inv,
                        input logic inx, input string tag);
      step(1'b1, f, tag);
      chk({tag, ".const_res"}, bus_if.int_out,       r);
      chk({tag, ".const_inv"}, 32'(bus_if.invalid), 32'(inv));
      chk({tag, ".const_inx"}, 32'(bus_if.inexact), 32'(inx));
   endtask

   initial begin
      logic [31:0] held;
      bus_if.in_valid = 1'b0;
      bus_if.float_in = 16'h0000;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_ov = 1'b0; exp_res = 32'd0; exp_inv = 1'b0; exp_inx = 1'b0;
      check_outputs("reset");
      rst_n = 1'b1;

      dstep(16'hC280, 32'hFFFF_FFFB, 1'b0, 1'b0, "neg5");
      dstep(16'h4280, 32'd5,         1'b0, 1'b0, "pos5");
      dstep(16'hC4C0, 32'hFFFF_FFF5, 1'b0, 1'b0, "neg11");
      dstep(16'h8000, 32'd0,         1'b0, 1'b0, "negzero");
      dstep(16'h0000, 32'd0,         1'b0, 1'b0, "zero");
      dstep(16'h3E00, 32'd1,         1'b0, 1'b0, "one");
      dstep(16'h3C00, 32'd0,         1'b0, 1'b1, "half");
`ifdef ROUND_NEAREST_EN
      dstep(16'h3F00, 32'd2,         1'b0, 1'b1, "one_half");
      dstep(16'h3D00, 32'd1,         1'b0, 1'b1, "three_quarter");
`else
      dstep(16'h3F00, 32'd1,         1'b0, 1'b1, "one_half");
      dstep(16'h3D00, 32'd0,         1'b0, 1'b1, "three_quarter");
`endif
      dstep(16'h4080, 32'd2,         1'b0, 1'b1, "two_half");
      dstep(16'h7DFF, 32'h7FFF_FFFF, 1'b1, 1'b0, "pos_ovf");
      dstep(16'hFDFF, 32'h8000_0000, 1'b1, 1'b0, "neg_ovf");
      dstep(16'hFC00, 32'h8000_0000, 1'b0, 1'b0, "int_min");
      dstep(16'h7C00, 32'h7FFF_FFFF, 1'b1, 1'b0, "pos_2p31");
      dstep(16'h7BFF, 32'h7FE0_0000, 1'b0, 1'b0, "max_exact");
      dstep(16'h7E00, 32'h7FFF_FFFF, 1'b1, 1'b0, "pos_special");
      dstep(16'hFFFF, 32'h8000_0000, 1'b1, 1'b0, "neg_special");

      held = bus_if.int_out;
      step(1'b0, 16'h4280, "idle1");
      step(1'b0, 16'hC4C0, "idle2");
      chk("hold_int_out", bus_if.int_out, held);

      step(1'b1, 16'h4280, "pre_reset");
      bus_if.in_valid = 1'b1;
      bus_if.float_in = 16'hC4C0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_ov = 1'b0; exp_res = 32'd0; exp_inv = 1'b0; exp_inx = 1'b0;
      check_outputs("mid_reset");
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0), 16'($urandom), "random");
      end
      step(1'b0, 16'h0000, "drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
